// File: rtl/mips_cpu_alu_pkg.sv
// alucontrol codes and state encoding shared by the HI/LO multiply/divide unit.
package mips_cpu_alu_pkg;

  localparam logic [4:0] MULTU = 5'b00111;
  localparam logic [4:0] MULT  = 5'b01000;
  localparam logic [4:0] DIV   = 5'b01111;
  localparam logic [4:0] DIVU  = 5'b10000;
  localparam logic [4:0] MTHI  = 5'b10001;
  localparam logic [4:0] MTLO  = 5'b10010;
  localparam logic [4:0] MFHI  = 5'b11010;
  localparam logic [4:0] MFLO  = 5'b11011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } muldiv_state_e;

endpackage

// File: rtl/mips_cpu_div_step.sv
// One restoring-division step: shift the next dividend bit into the remainder and
// subtract the divisor if it fits.
module mips_cpu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem_i, quo_i[WIDTH-1]};
  assign diff    = shifted - {1'b0, divisor_i};

  // The borrow out of the subtraction says the divisor did not fit.
  always_comb begin
    if (!diff[WIDTH]) begin
      rem_o = diff[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mips_cpu_hilo_muldiv.sv
// HI/LO unit: iterative MULT/MULTU/DIV/DIVU, MTHI/MTLO writes, MFHI/MFLO read mux.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiply; division stays iterative.
module mips_cpu_hilo_muldiv
  import mips_cpu_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [4:0]       alucontrol,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mfresult
);

  localparam int CW = $clog2(WIDTH);

  muldiv_state_e    state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             is_signed_op;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic [WIDTH-1:0] div_rem, div_quo;

  assign is_signed_op = (alucontrol == MULT) || (alucontrol == DIV);
  assign sign_a = is_signed_op & srca[WIDTH-1];
  assign sign_b = is_signed_op & srcb[WIDTH-1];
  assign abs_a  = sign_a ? -srca : srca;
  assign abs_b  = sign_b ? -srcb : srcb;

  // acc holds {partial product, remaining multiplier bits} during MUL.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // acc holds {remainder, quotient/dividend} during DIV; opnd is the divisor.
  mips_cpu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i     (acc_q[2*WIDTH-1:WIDTH]),
    .quo_i     (acc_q[WIDTH-1:0]),
    .divisor_i (opnd_q),
    .rem_o     (div_rem),
    .quo_o     (div_quo)
  );

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          unique case (alucontrol)
            MULT, MULTU: begin
              opnd_d    = abs_a;
              is_div_d  = 1'b0;
              neg_d     = sign_a ^ sign_b;
              rem_neg_d = 1'b0;
              cnt_d     = '0;
`ifdef MULDIV_FAST_MUL_EN
              acc_d   = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
              state_d = ST_FIX;
`else
              acc_d   = {{WIDTH{1'b0}}, abs_b};
              state_d = ST_MUL;
`endif
            end
            DIV, DIVU: begin
              opnd_d    = abs_b;
              acc_d     = {{WIDTH{1'b0}}, abs_a};
              is_div_d  = 1'b1;
              // A zero divisor leaves quotient all-ones and remainder = |dividend|;
              // suppressing quotient negation keeps lo at all-ones for any sign.
              neg_d     = (sign_a ^ sign_b) && (srcb != '0);
              rem_neg_d = sign_a;
              cnt_d     = '0;
              state_d   = ST_DIV;
            end
            MTHI:    hi_d = srca;
            MTLO:    lo_d = srca;
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = ST_FIX;
      end
      ST_DIV: begin
        acc_d = {div_rem, div_quo};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    mfresult = '0;
    if (alucontrol == MFHI) mfresult = hi_q;
    else if (alucontrol == MFLO) mfresult = lo_q;
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mips_cpu_hilo_muldiv.sv
// Self-checking bench for mips_cpu_hilo_muldiv: directed vector table, random ops
// against an arithmetic reference model, and hand-written multi-cycle sequences.
module tb_mips_cpu_hilo_muldiv;
  import mips_cpu_alu_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_BUSY = 1;
`else
  localparam int MUL_BUSY = 33;
`endif
  localparam int DIV_BUSY = 33;
  localparam int WINDOW   = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  alucontrol = 5'b0;
  logic [31:0] srca = '0;
  logic [31:0] srcb = '0;
  logic        busy, done;
  logic [31:0] hi, lo, mfresult;

  int checks = 0;
  int passes = 0;

  mips_cpu_hilo_muldiv #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .alucontrol (alucontrol),
    .srca       (srca),
    .srcb       (srcb),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo),
    .mfresult   (mfresult)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: plain 64-bit arithmetic straight from the MIPS rules.
  task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] h, output logic [31:0] l);
    longint sa, sb, q, r;
    logic [63:0] p;
    h = '0; l = '0;
    case (op)
      MULT: begin
        p = longint'($signed(a)) * longint'($signed(b));
        h = p[63:32]; l = p[31:0];
      end
      MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        h = p[63:32]; l = p[31:0];
      end
      DIV: begin
        if (b == 0) begin h = a; l = 32'hFFFFFFFF; end
        else begin
          sa = longint'($signed(a)); sb = longint'($signed(b));
          q = sa / sb; r = sa % sb;
          h = r[31:0]; l = q[31:0];
        end
      end
      DIVU: begin
        if (b == 0) begin h = a; l = 32'hFFFFFFFF; end
        else begin h = a % b; l = a / b; end
      end
      default: ;
    endcase
  endtask

  // Issue one op, watch a fixed window, report result and timing.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] h, output logic [31:0] l,
                        output int busy_n, output int done_n, output int done_at);
    busy_n = 0; done_n = 0; done_at = -1; h = 'x; l = 'x;
    @(negedge clk);
    start = 1'b1; alucontrol = op; srca = a; srcb = b;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= WINDOW; c++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_at < 0) begin done_at = c; h = hi; l = lo; end
      end
    end
  endtask

  task automatic check_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    logic [31:0] h, l;
    int bn, dn, da, eb;
    eb = (op == MULT || op == MULTU) ? MUL_BUSY : DIV_BUSY;
    run_op(op, a, b, h, l, bn, dn, da);
    chk({tag, "_hi"}, h, ehi);
    chk({tag, "_lo"}, l, elo);
    chk({tag, "_busy_cycles"}, bn, eb);
    chk({tag, "_done_pulses"}, dn, 1);
    chk({tag, "_done_cycle"}, da, eb + 1);
    $display("op=%b a=%h b=%h -> hi=%h lo=%h busy=%0d done@%0d", op, a, b, h, l, bn, da);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  vec_t vt[6];

  initial begin
    logic [31:0] eh, el, lo_before, h, l;
    logic [4:0]  op;
    logic [31:0] a, b;
    int          n, bn, dn, da;
    logic [4:0]  ops[4];
    ops[0] = MULT; ops[1] = MULTU; ops[2] = DIV; ops[3] = DIVU;

    vt[0] = '{MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vt[1] = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vt[2] = '{DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vt[3] = '{DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vt[4] = '{DIVU,  32'h00001234, 32'h0,        32'h00001234, 32'hFFFFFFFF};
    vt[5] = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;

    // Directed vectors
    foreach (vt[i]) check_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].ehi, vt[i].elo);

    // Random ops against the model
    for (int i = 0; i < 30; i++) begin
      op = ops[$urandom_range(0, 3)];
      a  = rnd_operand();
      b  = rnd_operand();
      model(op, a, b, eh, el);
      check_op($sformatf("rnd%0d", i), op, a, b, eh, el);
    end

    // MTHI then MFHI/MFLO read mux
    @(negedge clk);
    start = 1'b1; alucontrol = MTHI; srca = 32'hA5A5A5A5;
    @(posedge clk);
    #1 start = 1'b0; alucontrol = MFHI;
    #1 chk("mfhi_after_mthi", mfresult, 32'hA5A5A5A5);
    lo_before = lo;
    alucontrol = MFLO;
    #1 chk("mflo_read", mfresult, lo_before);
    alucontrol = DIVU;
    #1 chk("mf_other_zero", mfresult, 32'h0);
    $display("mthi a5a5a5a5 -> hi=%h", hi);

    // MTLO while busy is ignored
    @(negedge clk);
    start = 1'b1; alucontrol = DIVU; srca = 32'd1000; srcb = 32'd9;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; alucontrol = MTLO; srca = 32'hDEADBEEF;
    @(posedge clk);
    #1 start = 1'b0;
    chk("mtlo_busy_ignored", lo, lo_before);
    n = 0;
    while (!done && n < WINDOW) begin @(negedge clk); n++; end
    chk("mtlo_busy_done_seen", {31'd0, done}, 32'd1);
    chk("mtlo_busy_lo_result", lo, 32'd111);
    chk("mtlo_busy_hi_result", hi, 32'd1);
    $display("mtlo during divu 1000/9 -> hi=%h lo=%h", hi, lo);

    // MTLO in the done cycle is accepted
    @(negedge clk);
    start = 1'b1; alucontrol = MULTU; srca = 32'h00010000; srcb = 32'h00030000;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (!done && n < WINDOW) begin @(negedge clk); n++; end
    chk("done_cycle_seen", {31'd0, done}, 32'd1);
    start = 1'b1; alucontrol = MTLO; srca = 32'h13572468;
    @(posedge clk);
    #1 start = 1'b0;
    chk("mtlo_on_done_lo", lo, 32'h13572468);
    chk("mtlo_on_done_hi", hi, 32'h00000003);
    $display("mtlo on done cycle -> hi=%h lo=%h", hi, lo);

    // Reset during step 10 of a DIV
    @(negedge clk);
    start = 1'b1; alucontrol = DIV; srca = 32'hFFFF0000; srcb = 32'h7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int c = 0; c < WINDOW; c++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort_no_done", dn, 0);
    chk("abort_hi_stays", hi, 32'h0);
    $display("reset mid-div -> hi=%h lo=%h done_pulses=%0d", hi, lo, dn);

    // Multiply after abort, timing per build
    run_op(MULT, 32'h00000005, 32'hFFFFFFFD, h, l, bn, dn, da);
    chk("post_abort_mul_lo", l, 32'hFFFFFFF1);
    chk("post_abort_mul_hi", h, 32'hFFFFFFFF);
    chk("post_abort_done_cycle", da, MUL_BUSY + 1);
    $display("mult 5*-3 after abort -> hi=%h lo=%h done@%0d", h, l, da);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
